stream_qos_scheduler: RTL and testbench

Packet-locked QoS scheduler for the stream merge path. It picks one of STREAM_COUNT input streams and passes that stream's whole packet to the single output before it re-arbitrates. Selection uses QoS priority with round-robin tie-breaking. Per-stream age counters promote starved streams, so high-QoS traffic cannot starve a low-QoS requester indefinitely.

---
 rtl/stream_qos_scheduler.sv | 149 ++++++++++++++
 tb/tb_stream_qos_scheduler.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_qos_scheduler.sv
// Packet-locked QoS scheduler: merges STREAM_COUNT streams onto one output, one whole packet at a time,
// using QoS priority with round-robin ties and age-based starvation promotion.
module stream_qos_scheduler #(
   parameter  int T_DATA_WIDTH = 8,
   parameter  int T_QOS__WIDTH = 4,
   parameter  int STREAM_COUNT = 4,
   parameter  int AGE_WIDTH    = 6,
   localparam int T_ID___WIDTH = $clog2(STREAM_COUNT)
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0] s_data_i,
   input  logic [STREAM_COUNT-1:0][T_QOS__WIDTH-1:0] s_qos_i,
   input  logic [STREAM_COUNT-1:0]                  s_last_i,
   input  logic [STREAM_COUNT-1:0]                  s_valid_i,
   output logic [STREAM_COUNT-1:0]                  s_ready_o,
   output logic [T_DATA_WIDTH-1:0]                  m_data_o,
   output logic [T_QOS__WIDTH-1:0]                  m_qos_o,
   output logic [T_ID___WIDTH-1:0]                  m_id_o,
   output logic                                     m_last_o,
   output logic                                     m_valid_o,
   input  logic                                     m_ready_i,
   output logic [STREAM_COUNT-1:0]                  starve_o
);

   localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;

   typedef enum logic {IDLE, LOCK} state_t;

   state_t                                  state_reg, state_next;
   logic [T_ID___WIDTH-1:0]                 gnt_id_reg, gnt_id_next;
   logic [T_QOS__WIDTH-1:0]                 gnt_qos_reg, gnt_qos_next;
   logic [T_ID___WIDTH-1:0]                 rr_ptr_reg, rr_ptr_next;
   logic [STREAM_COUNT-1:0][AGE_WIDTH-1:0]  age_reg, age_next;

   logic [STREAM_COUNT-1:0]                 starving;
   logic [STREAM_COUNT-1:0]                 cand;
   logic [T_QOS__WIDTH-1:0]                 max_qos;
   logic [T_ID___WIDTH-1:0]                 winner;
   logic                                    any_valid;
   logic                                    grant_now;
   logic                                    eop;

   genvar gi;
   generate
      for (gi = 0; gi < STREAM_COUNT; gi++) begin : gen_starve
         assign starve_o[gi] = (age_reg[gi] == AGE_MAX);
         assign starving[gi] = s_valid_i[gi] && (age_reg[gi] == AGE_MAX);
      end
   endgenerate

   assign any_valid = |s_valid_i;
   assign grant_now = (state_reg == IDLE) && any_valid;
   assign eop       = (state_reg == LOCK) && m_valid_o && m_ready_i && m_last_o;

   // Starving requesters pre-empt QoS ranking; rr_ptr breaks ties among the candidates.
   always_comb begin
      int  idx;
      logic found;
      max_qos = '0;
      cand    = '0;
      winner  = '0;
      found   = 1'b0;
      idx     = 0;
      for (int i = 0; i < STREAM_COUNT; i++) begin
         if (s_valid_i[i] && (s_qos_i[i] > max_qos)) max_qos = s_qos_i[i];
      end
      for (int i = 0; i < STREAM_COUNT; i++) begin
         cand[i] = (|starving) ? starving[i] : (s_valid_i[i] && (s_qos_i[i] == max_qos));
      end
      for (int k = 0; k < STREAM_COUNT; k++) begin
         idx = int'(rr_ptr_reg) + k;
         if (idx >= STREAM_COUNT) idx = idx - STREAM_COUNT;
         if (!found && cand[idx]) begin
            winner = T_ID___WIDTH'(idx);
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      state_next   = state_reg;
      gnt_id_next  = gnt_id_reg;
      gnt_qos_next = gnt_qos_reg;
      rr_ptr_next  = rr_ptr_reg;
      case (state_reg)
         IDLE: begin
            if (any_valid) begin
               state_next   = LOCK;
               gnt_id_next  = winner;
               gnt_qos_next = s_qos_i[winner];
            end
         end
         LOCK: begin
            if (eop) begin
               state_next  = IDLE;
               rr_ptr_next = (gnt_id_reg == T_ID___WIDTH'(STREAM_COUNT - 1)) ? '0 : gnt_id_reg + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Ages count only cycles spent waiting; the lock holder and this cycle's winner are not waiting.
   always_comb begin
      age_next = age_reg;
      for (int i = 0; i < STREAM_COUNT; i++) begin
         if (eop && (gnt_id_reg == T_ID___WIDTH'(i))) begin
            age_next[i] = '0;
         end else if (s_valid_i[i] && (age_reg[i] != AGE_MAX) &&
                      !((state_reg == LOCK) && (gnt_id_reg == T_ID___WIDTH'(i))) &&
                      !(grant_now && (winner == T_ID___WIDTH'(i)))) begin
            age_next[i] = age_reg[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         gnt_id_reg  <= '0;
         gnt_qos_reg <= '0;
         rr_ptr_reg  <= '0;
         age_reg     <= '0;
      end else begin
         state_reg   <= state_next;
         gnt_id_reg  <= gnt_id_next;
         gnt_qos_reg <= gnt_qos_next;
         rr_ptr_reg  <= rr_ptr_next;
         age_reg     <= age_next;
      end
   end

   always_comb begin
      s_ready_o = '0;
      m_data_o  = '0;
      m_last_o  = 1'b0;
      m_valid_o = 1'b0;
      m_id_o    = gnt_id_reg;
      m_qos_o   = gnt_qos_reg;
      if (state_reg == LOCK) begin
         m_data_o              = s_data_i[gnt_id_reg];
         m_last_o              = s_last_i[gnt_id_reg];
         m_valid_o             = s_valid_i[gnt_id_reg];
         s_ready_o[gnt_id_reg] = m_ready_i;
      end
   end

endmodule

// File: tb/tb_stream_qos_scheduler.sv
// Self-checking bench for stream_qos_scheduler: per-stream beat queues feed the DUT and a
// scoreboard of expected output beats (stream, QoS, data, last, cycle) is checked on each handshake.
module tb_stream_qos_scheduler;

   localparam int DW = 8;
   localparam int QW = 4;
   localparam int N  = 4;
   localparam int AW = 3;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [N-1:0][DW-1:0] s_data;
   logic [N-1:0][QW-1:0] s_qos;
   logic [N-1:0]        s_last;
   logic [N-1:0]        s_valid;
   logic [N-1:0]        s_ready;
   logic [DW-1:0]       m_data;
   logic [QW-1:0]       m_qos;
   logic [1:0]          m_id;
   logic                m_last;
   logic                m_valid;
   logic                m_ready;
   logic [N-1:0]        starve;

   always #5 clk = ~clk;

   stream_qos_scheduler #(
      .T_DATA_WIDTH(DW),
      .T_QOS__WIDTH(QW),
      .STREAM_COUNT(N),
      .AGE_WIDTH   (AW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .s_data_i (s_data),
      .s_qos_i  (s_qos),
      .s_last_i (s_last),
      .s_valid_i(s_valid),
      .s_ready_o(s_ready),
      .m_data_o (m_data),
      .m_qos_o  (m_qos),
      .m_id_o   (m_id),
      .m_last_o (m_last),
      .m_valid_o(m_valid),
      .m_ready_i(m_ready),
      .starve_o (starve)
   );

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   typedef struct {
      logic [1:0]    id;
      logic [QW-1:0] qos;
      logic [DW-1:0] data;
      logic          last;
      int            cyc;
   } exp_t;

   beat_t        src_q[N][$];
   exp_t         sb[$];
   logic [N-1:0] vgate;
   int           cyc;
   int           vectors;
   int           miscompares;

   task automatic load_pkt(input int s, input int nbeats, input logic [DW-1:0] base);
      beat_t b;
      for (int k = 0; k < nbeats; k++) begin
         b.data = base + DW'(k);
         b.last = (k == nbeats - 1);
         src_q[s].push_back(b);
      end
   endtask

   task automatic push_exp(input int id, input int qos, input logic [DW-1:0] data, input logic last, input int c);
      exp_t e;
      e.id = 2'(id); e.qos = QW'(qos); e.data = data; e.last = last; e.cyc = c;
      sb.push_back(e);
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < N; i++) begin
         if (src_q[i].size() > 0 && vgate[i]) begin
            s_valid[i] = 1'b1;
            s_data[i]  = src_q[i][0].data;
            s_last[i]  = src_q[i][0].last;
         end else begin
            s_valid[i] = 1'b0;
            s_data[i]  = 8'hEE;
            s_last[i]  = 1'b0;
         end
      end
   endtask

   // Called at the falling edge: scoreboard compare, source pops, then advance one cycle.
   task automatic finish_cycle();
      exp_t e;
      if (m_valid && m_ready) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_beat cyc=%0d got id=%0d data=%h, scoreboard empty", cyc, m_id, m_data);
         end else begin
            e = sb.pop_front();
            if ({m_id, m_qos, m_data, m_last} !== {e.id, e.qos, e.data, e.last} || cyc != e.cyc) begin
               miscompares++;
               $display("FAIL beat got id=%0d qos=%0d data=%h last=%0d cyc=%0d exp id=%0d qos=%0d data=%h last=%0d cyc=%0d",
                        m_id, m_qos, m_data, m_last, cyc, e.id, e.qos, e.data, e.last, e.cyc);
            end
         end
      end
      for (int i = 0; i < N; i++) begin
         if (s_valid[i] && s_ready[i]) void'(src_q[i].pop_front());
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic step();
      drive_inputs();
      @(negedge clk);
      finish_cycle();
   endtask

   task automatic check_drained(input string name);
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL %s_drained got %0d beats outstanding, exp 0", name, sb.size());
      end
      sb.delete();
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      s_valid = '0;
      s_last  = '0;
      s_qos   = '0;
      m_ready = 1'b1;
      vgate   = '1;
      for (int i = 0; i < N; i++) src_q[i].delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc   = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int k = 0; k < 6; k++) begin
         s_data  = $urandom;
         s_qos   = 16'($urandom);
         s_last  = 4'($urandom);
         s_valid = 4'($urandom);
         m_ready = 1'($urandom);
         @(negedge clk);
         vectors++;
         if ({s_ready, m_data, m_qos, m_id, m_last, m_valid, starve} !== '0) begin
            miscompares++;
            $display("FAIL reset_hold k=%0d got s_ready=%b m_valid=%b m_data=%h m_id=%0d m_qos=%0d starve=%b, exp all 0",
                     k, s_ready, m_valid, m_data, m_id, m_qos, starve);
         end
         @(posedge clk);
         #1;
      end
      s_valid = '0;
      rst_n   = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         vectors++;
         if ({s_ready, m_data, m_qos, m_id, m_last, m_valid, starve} !== '0) begin
            miscompares++;
            $display("FAIL reset_release k=%0d got s_ready=%b m_valid=%b m_id=%0d m_qos=%0d, exp all 0",
                     k, s_ready, m_valid, m_id, m_qos);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_qos_priority();
      do_reset();
      s_qos[1] = 4'd2;
      s_qos[3] = 4'd7;
      load_pkt(1, 3, 8'h10);
      load_pkt(3, 3, 8'h30);
      push_exp(3, 7, 8'h30, 1'b0, 1);
      push_exp(3, 7, 8'h31, 1'b0, 2);
      push_exp(3, 7, 8'h32, 1'b1, 3);
      push_exp(1, 2, 8'h10, 1'b0, 5);
      push_exp(1, 2, 8'h11, 1'b0, 6);
      push_exp(1, 2, 8'h12, 1'b1, 7);
      for (int k = 0; k < 10; k++) step();
      check_drained("qos_priority");
   endtask

   task automatic test_round_robin();
      do_reset();
      s_qos = {4'd5, 4'd5, 4'd5, 4'd5};
      load_pkt(0, 1, 8'h00);
      load_pkt(0, 1, 8'h01);
      load_pkt(1, 1, 8'h10);
      load_pkt(1, 1, 8'h11);
      load_pkt(2, 1, 8'h20);
      load_pkt(3, 1, 8'h30);
      push_exp(0, 5, 8'h00, 1'b1, 1);
      push_exp(1, 5, 8'h10, 1'b1, 3);
      push_exp(2, 5, 8'h20, 1'b1, 5);
      push_exp(3, 5, 8'h30, 1'b1, 7);
      push_exp(0, 5, 8'h01, 1'b1, 9);
      push_exp(1, 5, 8'h11, 1'b1, 11);
      for (int k = 0; k < 13; k++) step();
      check_drained("round_robin");
   endtask

   task automatic test_starvation();
      do_reset();
      s_qos[0] = 4'd0;
      s_qos[1] = 4'd15;
      load_pkt(0, 1, 8'h05);
      for (int p = 0; p < 6; p++) load_pkt(1, 1, 8'h40 + 8'(p));
      for (int p = 0; p < 4; p++) push_exp(1, 15, 8'h40 + 8'(p), 1'b1, 2 * p + 1);
      push_exp(0, 0, 8'h05, 1'b1, 9);
      push_exp(1, 15, 8'h44, 1'b1, 11);
      push_exp(1, 15, 8'h45, 1'b1, 13);
      for (int k = 0; k < 15; k++) begin
         step();
         if (k == 5 || k == 6 || k == 9) begin
            vectors++;
            if (starve[0] !== (k == 6)) begin
               miscompares++;
               $display("FAIL starve_flag cyc=%0d got starve[0]=%b exp %b", cyc, starve[0], (k == 6));
            end
         end
      end
      check_drained("starvation");
   endtask

   task automatic test_backpressure();
      do_reset();
      s_qos[2] = 4'd9;
      load_pkt(2, 4, 8'h20);
      push_exp(2, 9, 8'h20, 1'b0, 1);
      push_exp(2, 9, 8'h21, 1'b0, 7);
      push_exp(2, 9, 8'h22, 1'b0, 8);
      push_exp(2, 9, 8'h23, 1'b1, 9);
      for (int k = 0; k < 12; k++) begin
         m_ready  = !(k >= 2 && k <= 4);
         vgate[2] = !(k == 5 || k == 6);
         if (k >= 2) s_qos[2] = 4'd3;
         drive_inputs();
         @(negedge clk);
         vectors++;
         if ((s_ready & 4'b1011) !== 4'b0000) begin
            miscompares++;
            $display("FAIL bp_other_ready k=%0d got s_ready=%b exp 0 on streams 0,1,3", k, s_ready);
         end
         if (k >= 1 && k <= 9) begin
            vectors++;
            if (m_id !== 2'd2 || s_ready[2] !== m_ready) begin
               miscompares++;
               $display("FAIL bp_lock k=%0d got m_id=%0d s_ready[2]=%b exp m_id=2 s_ready[2]=%b", k, m_id, s_ready[2], m_ready);
            end
         end
         if (k >= 2 && k <= 6) begin
            vectors++;
            if (m_valid !== (k <= 4)) begin
               miscompares++;
               $display("FAIL bp_valid k=%0d got m_valid=%b exp %b", k, m_valid, (k <= 4));
            end
         end
         finish_cycle();
      end
      m_ready = 1'b1;
      vgate   = '1;
      check_drained("backpressure");
   endtask

   task automatic test_reset_mid_packet();
      do_reset();
      load_pkt(2, 1, 8'h50);
      load_pkt(2, 5, 8'h60);
      push_exp(2, 0, 8'h50, 1'b1, 1);
      push_exp(2, 0, 8'h60, 1'b0, 3);
      push_exp(2, 0, 8'h61, 1'b0, 4);
      for (int k = 0; k < 5; k++) step();
      drive_inputs();
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({s_ready, m_data, m_qos, m_id, m_last, m_valid, starve} !== '0) begin
         miscompares++;
         $display("FAIL reset_mid_outputs got s_ready=%b m_valid=%b m_data=%h m_id=%0d, exp all 0",
                  s_ready, m_valid, m_data, m_id);
      end
      check_drained("reset_mid_pre");
      for (int i = 0; i < N; i++) src_q[i].delete();
      s_valid = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc   = 0;
      load_pkt(1, 1, 8'h70);
      load_pkt(3, 1, 8'h71);
      push_exp(1, 0, 8'h70, 1'b1, 1);
      push_exp(3, 0, 8'h71, 1'b1, 3);
      for (int k = 0; k < 6; k++) step();
      check_drained("reset_mid_post");
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      cyc         = 0;
      rst_n       = 1'b0;
      s_data      = '0;
      s_qos       = '0;
      s_last      = '0;
      s_valid     = '0;
      m_ready     = 1'b1;
      vgate       = '1;
      test_reset();
      test_qos_priority();
      test_round_robin();
      test_starvation();
      test_backpressure();
      test_reset_mid_packet();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
